// File: rtl/zbus_ser_tx.sv
// zbus serializing transmitter: one BN-beat word in, BN narrow beats out, LSB beat first.
// With PK=1 a word is launched only once the downstream FIFO reports room for the whole packet.
module zbus_ser_tx #(
  parameter int BW  = 8,
  parameter int BN  = 4,
  parameter int CNL = 3,
  parameter int PK  = 1
) (
  input  logic                 zo_clk,
  input  logic                 zo_rst,
  input  logic                 zi_vld,
  input  logic [BN*BW-1:0]     zi_bus,
  output logic                 zi_ack,
  output logic                 zo_vld,
  output logic [BW-1:0]        zo_bus,
  output logic                 zo_lst,
  input  logic [CNL-1:0]       zo_num,
  input  logic                 zo_ack
);

  localparam int              BCW       = (BN > 1) ? $clog2(BN) : 1;
  localparam logic [BCW-1:0]  LAST_BEAT = BCW'(BN - 1);
  localparam logic [CNL-1:0]  PKT_ROOM  = CNL'(BN);
  localparam logic            ONE_BEAT  = (BN == 1);
  localparam logic            PKT_MODE  = (PK != 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_SEND = 2'd2
  } state_t;

  state_t              state_r;
  logic [BN*BW-1:0]    sreg_r;
  logic [BCW-1:0]      bcnt_r;
  logic                vld_r;
  logic                lst_r;

  logic                last_s;
  logic                room_s;
  logic                zo_trn_s;
  logic [BCW-1:0]      bcnt_inc_s;

  // Beat position, downstream room and the input handshake decode.
  always_comb begin
    last_s     = (bcnt_r == LAST_BEAT);
    room_s     = (zo_num >= PKT_ROOM);
    zo_trn_s   = vld_r & zo_ack;
    bcnt_inc_s = bcnt_r + BCW'(1);
    zi_ack     = (state_r == ST_IDLE) | ((state_r == ST_SEND) & zo_ack & last_s);
  end

  assign zo_vld = vld_r;
  assign zo_bus = sreg_r[BW-1:0];
  assign zo_lst = lst_r;

  // Control FSM with shift register and registered beat flags.
  always_ff @(posedge zo_clk or posedge zo_rst) begin
    if (zo_rst) begin
      state_r <= ST_IDLE;
      sreg_r  <= '0;
      bcnt_r  <= '0;
      vld_r   <= 1'b0;
      lst_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          // zi_bus is captured only when valid so undriven data never reaches sreg
          if (zi_vld) begin
            sreg_r <= zi_bus;
            bcnt_r <= '0;
            if (PKT_MODE) begin
              state_r <= ST_WAIT;
              vld_r   <= 1'b0;
              lst_r   <= 1'b0;
            end else begin
              state_r <= ST_SEND;
              vld_r   <= 1'b1;
              lst_r   <= ONE_BEAT;
            end
          end else begin
            state_r <= ST_IDLE;
            vld_r   <= 1'b0;
            lst_r   <= 1'b0;
          end
        end

        ST_WAIT: begin
          if (room_s) begin
            state_r <= ST_SEND;
            vld_r   <= 1'b1;
            lst_r   <= last_s;
          end else begin
            state_r <= ST_WAIT;
            vld_r   <= 1'b0;
            lst_r   <= 1'b0;
          end
        end

        ST_SEND: begin
          if (zo_trn_s && !last_s) begin
            sreg_r <= sreg_r >> BW;
            bcnt_r <= bcnt_inc_s;
            lst_r  <= (bcnt_inc_s == LAST_BEAT);
          end else if (zo_trn_s && zi_vld) begin
            // back-to-back reload; packet mode re-checks room via WAIT
            sreg_r <= zi_bus;
            bcnt_r <= '0;
            if (PKT_MODE) begin
              state_r <= ST_WAIT;
              vld_r   <= 1'b0;
              lst_r   <= 1'b0;
            end else begin
              state_r <= ST_SEND;
              vld_r   <= 1'b1;
              lst_r   <= ONE_BEAT;
            end
          end else if (zo_trn_s) begin
            state_r <= ST_IDLE;
            vld_r   <= 1'b0;
            lst_r   <= 1'b0;
          end else begin
            state_r <= ST_SEND;
            vld_r   <= 1'b1;
            lst_r   <= last_s;
          end
        end

        default: begin
          state_r <= ST_IDLE;
          vld_r   <= 1'b0;
          lst_r   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_zbus_ser_tx.sv
// Directed bench for zbus_ser_tx: a PK=0 and a PK=1 instance share stimulus, each tracked
// by a queue-of-beats model, plus literal checks of the documented scenarios.
module tb_zbus_ser_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        vld;
  logic [31:0] bus;
  logic        oack;
  logic [2:0]  num;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  task automatic chk1(string nm, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk8(string nm, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // instance g has PK=g; its model holds the beats of the word in flight
  for (genvar g = 0; g < 2; g++) begin : gm
    logic       zi_ack;
    logic       zo_vld;
    logic       zo_lst;
    logic [7:0] zo_bus;

    zbus_ser_tx #(.BW(8), .BN(4), .CNL(3), .PK(g)) u_dut (
      .zo_clk (clk),
      .zo_rst (rst),
      .zi_vld (vld),
      .zi_bus (bus),
      .zi_ack (zi_ack),
      .zo_vld (zo_vld),
      .zo_bus (zo_bus),
      .zo_lst (zo_lst),
      .zo_num (num),
      .zo_ack (oack)
    );

    logic [7:0] q[$];
    bit         armed;
    int         sz;
    logic [7:0] head;

    // Model: a word becomes four queued beats; beats are visible only while armed.
    always @(posedge clk or posedge rst) begin
      if (rst) begin
        q.delete();
        armed = 1'b0;
      end else if (armed && oack) begin
        void'(q.pop_front());
        if (q.size() == 0) begin
          armed = 1'b0;
          if (vld) begin
            for (int k = 0; k < 4; k++) q.push_back(bus[8*k +: 8]);
            armed = (g == 0);
          end
        end
      end else if (q.size() == 0) begin
        if (vld) begin
          for (int k = 0; k < 4; k++) q.push_back(bus[8*k +: 8]);
          armed = (g == 0);
        end
      end else if (!armed && num >= 3'd4) begin
        armed = 1'b1;
      end
      sz   = q.size();
      head = (q.size() != 0) ? q[0] : 8'h00;
    end
  end

  task automatic cmp_inst(int g, bit armed, int sz, logic [7:0] head,
                          logic a_ack, logic a_vld, logic [7:0] a_bus, logic a_lst);
    string p;
    p = $sformatf("m%0d.", g);
    chk1({p, "zi_ack"}, a_ack, (sz == 0) || (armed && oack && sz == 1));
    chk1({p, "zo_vld"}, a_vld, armed);
    chk1({p, "zo_lst"}, a_lst, armed && sz == 1);
    if (armed) chk8({p, "zo_bus"}, a_bus, head);
  endtask

  // Compare both instances against their models away from the active edge.
  always @(negedge clk) begin
    cmp_inst(0, gm[0].armed, gm[0].sz, gm[0].head,
             gm[0].zi_ack, gm[0].zo_vld, gm[0].zo_bus, gm[0].zo_lst);
    cmp_inst(1, gm[1].armed, gm[1].sz, gm[1].head,
             gm[1].zi_ack, gm[1].zo_vld, gm[1].zo_bus, gm[1].zo_lst);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    vld = 1'b0;
    bus = 'x;
    repeat (n) cyc();
  endtask

  logic [7:0] b2b [8];

  initial begin
    b2b = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33, 8'h44};
    rst = 1'b1; vld = 1'b0; bus = '0; oack = 1'b1; num = 3'd4;
    #3;
    for (int g = 0; g < 2; g++) begin
      chk1("rst.zi_ack", (g == 0) ? gm[0].zi_ack : gm[1].zi_ack, 1'b1);
      chk1("rst.zo_vld", (g == 0) ? gm[0].zo_vld : gm[1].zo_vld, 1'b0);
      chk1("rst.zo_lst", (g == 0) ? gm[0].zo_lst : gm[1].zo_lst, 1'b0);
      chk8("rst.zo_bus", (g == 0) ? gm[0].zo_bus : gm[1].zo_bus, 8'h00);
    end
    cyc(); cyc();
    rst = 1'b0;
    idle(2);

    // single word, streaming
    vld = 1'b1; bus = 32'h44332211;
    cyc();
    vld = 1'b0; bus = 'x;
    for (int i = 0; i < 4; i++) begin
      chk8("single.bus", gm[0].zo_bus, 8'(17 * (i + 1)));
      chk1("single.vld", gm[0].zo_vld, 1'b1);
      chk1("single.lst", gm[0].zo_lst, i == 3);
      cyc();
    end
    chk1("single.end", gm[0].zo_vld, 1'b0);
    idle(8);

    // backpressure on beat 1
    vld = 1'b1; bus = 32'h44332211;
    cyc();
    vld = 1'b0; bus = 'x;
    chk8("bp.b0", gm[0].zo_bus, 8'h11);
    cyc();
    oack = 1'b0;
    repeat (3) begin
      chk8("bp.hold", gm[0].zo_bus, 8'h22);
      chk1("bp.vld", gm[0].zo_vld, 1'b1);
      chk1("bp.ack", gm[0].zi_ack, 1'b0);
      cyc();
    end
    oack = 1'b1;
    chk8("bp.hold4", gm[0].zo_bus, 8'h22);
    cyc();
    chk8("bp.b2", gm[0].zo_bus, 8'h33);
    cyc();
    chk8("bp.b3", gm[0].zo_bus, 8'h44);
    idle(10);

    // back-to-back words without a gap
    vld = 1'b1; bus = 32'hDDCCBBAA;
    cyc();
    bus = 32'h44332211;
    for (int i = 0; i < 8; i++) begin
      chk8("b2b.bus", gm[0].zo_bus, b2b[i]);
      chk1("b2b.vld", gm[0].zo_vld, 1'b1);
      chk1("b2b.lst", gm[0].zo_lst, (i == 3) || (i == 7));
      if (i < 3) chk1("b2b.noack", gm[0].zi_ack, 1'b0);
      if (i == 3) chk1("b2b.ack", gm[0].zi_ack, 1'b1);
      cyc();
      if (i == 3) begin
        vld = 1'b0; bus = 'x;
      end
    end
    chk1("b2b.end", gm[0].zo_vld, 1'b0);
    idle(12);

    // packet gating on the PK=1 instance
    num = 3'd3;
    vld = 1'b1; bus = 32'h88776655;
    cyc();
    vld = 1'b0; bus = 'x;
    repeat (3) begin
      chk1("pk.gated", gm[1].zo_vld, 1'b0);
      cyc();
    end
    num = 3'd4;
    cyc();
    chk1("pk.open", gm[1].zo_vld, 1'b1);
    chk8("pk.b0", gm[1].zo_bus, 8'h55);
    num = 3'd0;
    for (int i = 1; i < 4; i++) begin
      cyc();
      chk1("pk.vld", gm[1].zo_vld, 1'b1);
      chk8("pk.bus", gm[1].zo_bus, 8'(8'h55 + 17 * i));
      chk1("pk.lst", gm[1].zo_lst, i == 3);
    end
    cyc();
    chk1("pk.end", gm[1].zo_vld, 1'b0);
    num = 3'd4;
    idle(8);

    // asynchronous reset mid-packet
    vld = 1'b1; bus = 32'h44332211;
    cyc();
    vld = 1'b0; bus = 'x;
    cyc();
    chk8("mid.b1", gm[0].zo_bus, 8'h22);
    #2 rst = 1'b1;
    #1;
    chk1("mid.vld0", gm[0].zo_vld, 1'b0);
    chk1("mid.vld1", gm[1].zo_vld, 1'b0);
    chk8("mid.bus0", gm[0].zo_bus, 8'h00);
    @(posedge clk);
    #1 rst = 1'b0;
    chk1("mid.ack", gm[0].zi_ack, 1'b1);
    vld = 1'b1; bus = 32'hA4A3A2A1;
    cyc();
    vld = 1'b0; bus = 'x;
    chk1("mid.restart.vld", gm[0].zo_vld, 1'b1);
    chk8("mid.restart.b0", gm[0].zo_bus, 8'hA1);
    idle(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
